// File: rtl/sfp_pkg.sv
// rtl/sfp_pkg.sv - state encoding, status bit indices and helpers for the SFP link controller
package sfp_pkg;

    localparam logic [2:0] ENC_ABSENT     = 3'd0;
    localparam logic [2:0] ENC_SETTLE     = 3'd1;
    localparam logic [2:0] ENC_INIT       = 3'd2;
    localparam logic [2:0] ENC_READY      = 3'd3;
    localparam logic [2:0] ENC_FAULT_RST  = 3'd4;
    localparam logic [2:0] ENC_FAULT_LOCK = 3'd5;

    typedef enum logic [2:0] {
        ST_ABSENT     = ENC_ABSENT,
        ST_SETTLE     = ENC_SETTLE,
        ST_INIT       = ENC_INIT,
        ST_READY      = ENC_READY,
        ST_FAULT_RST  = ENC_FAULT_RST,
        ST_FAULT_LOCK = ENC_FAULT_LOCK
    } sfp_state_t;

    localparam int BIT_MOD_ABS  = 0;
    localparam int BIT_RX_LOS   = 1;
    localparam int BIT_TX_FAULT = 2;
    localparam int NUM_STATUS   = 3;

    // Safe-side reset values: module absent, no signal, no fault.
    localparam logic [NUM_STATUS-1:0] STATUS_RST = 3'b011;

    // States in which the laser must be held off regardless of software.
    function automatic logic tx_held_off(input sfp_state_t s);
        return (s == ST_ABSENT) || (s == ST_SETTLE) ||
               (s == ST_FAULT_RST) || (s == ST_FAULT_LOCK);
    endfunction

endpackage

// File: rtl/sfp_link_ctrl_if.sv
// rtl/sfp_link_ctrl_if.sv - cage pins, software controls and status outputs of one SFP cage
interface sfp_link_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             mod_abs_s;
    logic             rx_los_s;
    logic             tx_fault_s;
    logic             force_disable;
    logic             fault_clr;
    logic             tx_disable;
    logic             sfp_present;
    logic             rx_signal_ok;
    logic             link_ready;
    logic             fault_latched;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt_insert;
    logic [CNT_W-1:0] cnt_los;
    logic [CNT_W-1:0] cnt_fault;

    modport slave (
        input  mod_abs_s, rx_los_s, tx_fault_s, force_disable, fault_clr,
        output tx_disable, sfp_present, rx_signal_ok, link_ready, fault_latched,
               state, cnt_insert, cnt_los, cnt_fault
    );

    modport master (
        output mod_abs_s, rx_los_s, tx_fault_s, force_disable, fault_clr,
        input  tx_disable, sfp_present, rx_signal_ok, link_ready, fault_latched,
               state, cnt_insert, cnt_los, cnt_fault
    );
endinterface

// File: rtl/sfp_debounce.sv
// rtl/sfp_debounce.sv - single status bit debouncer, flips after DEB_CYCLES+1 disagreeing samples
module sfp_debounce #(
    parameter int   DEB_CYCLES = 1000,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= RST_VAL;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES)) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/sfp_link_ctrl.sv
// rtl/sfp_link_ctrl.sv - per-cage SFP presence/fault sequencer; event counters built only with SFP_EVENT_CNT_EN
module sfp_link_ctrl
    import sfp_pkg::*;
#(
    parameter int DEB_CYCLES = 1000,
    parameter int T_INSERT   = 10000,
    parameter int T_INIT     = 50000,
    parameter int T_RESET    = 100,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    sfp_link_ctrl_if.slave bus
);
    localparam int T_MAX = (T_INSERT > T_INIT)
                         ? ((T_INSERT > T_RESET) ? T_INSERT : T_RESET)
                         : ((T_INIT   > T_RESET) ? T_INIT   : T_RESET);
    localparam int TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    // Timer is loaded with T-1 and the state is left when it reads zero,
    // giving exactly T cycles of residency.
    localparam logic [TMR_W-1:0] LD_INSERT = TMR_W'(T_INSERT - 1);
    localparam logic [TMR_W-1:0] LD_INIT   = TMR_W'(T_INIT - 1);
    localparam logic [TMR_W-1:0] LD_RESET  = TMR_W'(T_RESET - 1);

    logic [NUM_STATUS-1:0] pins;
    logic [NUM_STATUS-1:0] deb;
    logic                  mod_abs_db, rx_los_db, tx_fault_db;

    sfp_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             tx_disable_q, link_ready_q;

    assign pins[BIT_MOD_ABS]  = bus.mod_abs_s;
    assign pins[BIT_RX_LOS]   = bus.rx_los_s;
    assign pins[BIT_TX_FAULT] = bus.tx_fault_s;

    for (genvar g = 0; g < NUM_STATUS; g++) begin : g_deb
        sfp_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_VAL    (STATUS_RST[g])
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (pins[g]),
            .dout (deb[g])
        );
    end

    assign mod_abs_db  = deb[BIT_MOD_ABS];
    assign rx_los_db   = deb[BIT_RX_LOS];
    assign tx_fault_db = deb[BIT_TX_FAULT];

    // Next-state, timer and retry logic; removal overrides everything else.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        retry_d = retry_q;
        if (mod_abs_db) begin
            state_d = ST_ABSENT;
            tmr_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_ABSENT: begin
                    state_d = ST_SETTLE;
                    tmr_d   = LD_INSERT;
                end
                ST_SETTLE: begin
                    if (!bus.force_disable) begin
                        if (tmr_q == '0) begin
                            state_d = ST_INIT;
                            tmr_d   = LD_INIT;
                        end else begin
                            tmr_d = tmr_q - TMR_W'(1);
                        end
                    end
                end
                ST_INIT: begin
                    if (bus.force_disable) begin
                        state_d = ST_SETTLE;
                        tmr_d   = LD_INSERT;
                    end else if (tmr_q == '0) begin
                        if (tx_fault_db) begin
                            state_d = ST_FAULT_RST;
                            tmr_d   = LD_RESET;
                            retry_d = retry_q + RTY_W'(1);
                        end else begin
                            state_d = ST_READY;
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_READY: begin
                    if (bus.force_disable) begin
                        state_d = ST_SETTLE;
                        tmr_d   = LD_INSERT;
                    end else if (tx_fault_db) begin
                        state_d = ST_FAULT_RST;
                        tmr_d   = LD_RESET;
                        retry_d = retry_q + RTY_W'(1);
                    end
                end
                ST_FAULT_RST: begin
                    if (tmr_q == '0) begin
                        if (retry_q <= RTY_W'(MAX_RETRY)) begin
                            state_d = ST_INIT;
                            tmr_d   = LD_INIT;
                        end else begin
                            state_d = ST_FAULT_LOCK;
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_FAULT_LOCK: begin
                    if (bus.fault_clr) begin
                        state_d = ST_INIT;
                        tmr_d   = LD_INIT;
                        retry_d = '0;
                    end
                end
                default: state_d = ST_ABSENT;
            endcase
        end
    end

    // State register plus registered pin and link outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ABSENT;
            tmr_q        <= '0;
            retry_q      <= '0;
            tx_disable_q <= 1'b1;
            link_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            retry_q      <= retry_d;
            tx_disable_q <= tx_held_off(state_d) | bus.force_disable;
            link_ready_q <= (state_q == ST_READY) & ~rx_los_db & ~bus.force_disable;
        end
    end

    assign bus.tx_disable    = tx_disable_q;
    assign bus.link_ready    = link_ready_q;
    assign bus.sfp_present   = ~mod_abs_db;
    assign bus.rx_signal_ok  = ~rx_los_db;
    assign bus.fault_latched = (state_q == ST_FAULT_LOCK);
    assign bus.state         = state_q;

`ifdef SFP_EVENT_CNT_EN
    logic [CNT_W-1:0] cnt_ins_q, cnt_los_q, cnt_flt_q;
    logic             los_prev_q;
    logic             ev_insert, ev_los, ev_fault;

    assign ev_insert = (state_q == ST_ABSENT) && (state_d == ST_SETTLE);
    assign ev_fault  = (state_d == ST_FAULT_RST) && (state_q != ST_FAULT_RST);
    assign ev_los    = rx_los_db && !los_prev_q && !mod_abs_db;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ins_q  <= '0;
            cnt_los_q  <= '0;
            cnt_flt_q  <= '0;
            los_prev_q <= 1'b1;
        end else begin
            los_prev_q <= rx_los_db;
            if (ev_insert && !(&cnt_ins_q)) cnt_ins_q <= cnt_ins_q + CNT_W'(1);
            if (ev_los    && !(&cnt_los_q)) cnt_los_q <= cnt_los_q + CNT_W'(1);
            if (ev_fault  && !(&cnt_flt_q)) cnt_flt_q <= cnt_flt_q + CNT_W'(1);
        end
    end

    assign bus.cnt_insert = cnt_ins_q;
    assign bus.cnt_los    = cnt_los_q;
    assign bus.cnt_fault  = cnt_flt_q;
`else
    assign bus.cnt_insert = {CNT_W{1'b0}};
    assign bus.cnt_los    = {CNT_W{1'b0}};
    assign bus.cnt_fault  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// tb/tb_sfp_link_ctrl.sv - scoreboard bench for sfp_link_ctrl against a behavioural cage model
module tb_sfp_link_ctrl;

    localparam int DEB       = 4;
    localparam int T_INSERT  = 8;
    localparam int T_INIT    = 16;
    localparam int T_RESET   = 3;
    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 2;
`ifdef SFP_EVENT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int S_ABSENT = 0, S_SETTLE = 1, S_INIT = 2, S_READY = 3, S_FRST = 4, S_LOCK = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sfp_link_ctrl_if #(.CNT_W(CNT_W)) bus ();

    sfp_link_ctrl #(
        .DEB_CYCLES(DEB), .T_INSERT(T_INSERT), .T_INIT(T_INIT),
        .T_RESET(T_RESET), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int mon_n  = 0;
    bit mon_en = 1'b0;
    logic [13:0] exp_q[$];

    // Reference model: debounced pins, state, time spent in state, retry and event tallies.
    int m_st, m_el, m_rty, m_ci, m_cl, m_cf;
    bit m_abs, m_los, m_flt, m_lprev, m_txd, m_link;
    int run_a, run_l, run_f;
    bit last_a, last_l, last_f;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_ABSENT; m_el = 0; m_rty = 0;
        m_ci = 0; m_cl = 0; m_cf = 0;
        m_abs = 1'b1; m_los = 1'b1; m_flt = 1'b0; m_lprev = 1'b1;
        m_txd = 1'b1; m_link = 1'b0;
        run_a = 0; run_l = 0; run_f = 0;
        last_a = 1'b0; last_l = 1'b0; last_f = 1'b0;
    endtask

    function automatic int sat(input int v);
        return (v < (1 << CNT_W) - 1) ? v + 1 : v;
    endfunction

    // A pin's debounced value follows the raw pin once it has held still for DEB+1 samples.
    task automatic deb_upd(input bit s, inout int run, inout bit last, inout bit db);
        if (run > 0 && s == last) run++;
        else run = 1;
        last = s;
        if (run >= DEB + 1) db = s;
    endtask

    task automatic model_step(input bit a, input bit l, input bit f, input bit frc, input bit clr);
        int ns;
        bit fault_in;
        ns = m_st;
        fault_in = 1'b0;
        if (m_abs) begin
            ns = S_ABSENT;
            m_rty = 0;
        end else begin
            case (m_st)
                S_ABSENT: begin ns = S_SETTLE; m_el = 1; m_ci = sat(m_ci); end
                S_SETTLE: if (!frc) begin
                    if (m_el == T_INSERT) begin ns = S_INIT; m_el = 1; end
                    else m_el++;
                end
                S_INIT: begin
                    if (frc) begin ns = S_SETTLE; m_el = 1; end
                    else if (m_el == T_INIT) begin
                        if (m_flt) fault_in = 1'b1;
                        else ns = S_READY;
                    end else m_el++;
                end
                S_READY: begin
                    if (frc) begin ns = S_SETTLE; m_el = 1; end
                    else if (m_flt) fault_in = 1'b1;
                end
                S_FRST: begin
                    if (m_el == T_RESET) begin
                        if (m_rty <= MAX_RETRY) begin ns = S_INIT; m_el = 1; end
                        else ns = S_LOCK;
                    end else m_el++;
                end
                S_LOCK: if (clr) begin ns = S_INIT; m_el = 1; m_rty = 0; end
                default: ns = S_ABSENT;
            endcase
        end
        if (fault_in) begin
            ns = S_FRST; m_el = 1; m_rty++; m_cf = sat(m_cf);
        end
        m_link = (m_st == S_READY) && !m_los && !frc;
        if (m_los && !m_lprev && !m_abs) m_cl = sat(m_cl);
        m_lprev = m_los;
        m_txd = (ns == S_ABSENT) || (ns == S_SETTLE) || (ns == S_FRST) || (ns == S_LOCK) || frc;
        m_st = ns;
        deb_upd(a, run_a, last_a, m_abs);
        deb_upd(l, run_l, last_l, m_los);
        deb_upd(f, run_f, last_f, m_flt);
    endtask

    function automatic logic [13:0] model_pack();
        logic [1:0] ci, cl, cf;
        logic [2:0] st;
        ci = CNT_EN ? 2'(m_ci) : 2'd0;
        cl = CNT_EN ? 2'(m_cl) : 2'd0;
        cf = CNT_EN ? 2'(m_cf) : 2'd0;
        st = 3'(m_st);
        return {m_txd, ~m_abs, ~m_los, m_link, (m_st == S_LOCK), st, ci, cl, cf};
    endfunction

    function automatic logic [13:0] dut_pack();
        return {bus.tx_disable, bus.sfp_present, bus.rx_signal_ok, bus.link_ready,
                bus.fault_latched, bus.state, bus.cnt_insert, bus.cnt_los, bus.cnt_fault};
    endfunction

    task automatic step(input bit a, input bit l, input bit f, input bit frc, input bit clr);
        @(negedge clk);
        bus.mod_abs_s     = a;
        bus.rx_los_s      = l;
        bus.tx_fault_s    = f;
        bus.force_disable = frc;
        bus.fault_clr     = clr;
        model_step(a, l, f, frc, clr);
        exp_q.push_back(model_pack());
        mon_en = 1'b1;
    endtask

    task automatic hold(input int n, input bit a, input bit l, input bit f, input bit frc);
        for (int i = 0; i < n; i++) step(a, l, f, frc, 1'b0);
    endtask

    task automatic settle_sample();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pop one expected output word per clock and compare.
    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard underflow at sample %0d", mon_n);
            end else begin
                logic [13:0] e, g;
                e = exp_q.pop_front();
                g = dut_pack();
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs sample %0d: got %h expected %h", mon_n, g, e);
                end
            end
            mon_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a, l, f, frc;
        int ra, rl, rf;
        bit hit;

        bus.mod_abs_s = 1'b0; bus.rx_los_s = 1'b0; bus.tx_fault_s = 1'b0;
        bus.force_disable = 1'b0; bus.fault_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset tx_disable", int'(bus.tx_disable), 1);
        chk("reset state", int'(bus.state), S_ABSENT);
        chk("reset sfp_present", int'(bus.sfp_present), 0);
        chk("reset rx_signal_ok", int'(bus.rx_signal_ok), 0);
        chk("reset link_ready", int'(bus.link_ready), 0);
        chk("reset fault_latched", int'(bus.fault_latched), 0);
        chk("reset cnt_insert", int'(bus.cnt_insert), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Clean insertion with spec latencies checked as constants.
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            settle_sample();
            case (k)
                4:  chk("present before debounce", int'(bus.sfp_present), 0);
                5:  begin
                        chk("present at +5", int'(bus.sfp_present), 1);
                        chk("still ABSENT at +5", int'(bus.state), S_ABSENT);
                    end
                6:  chk("enter SETTLE", int'(bus.state), S_SETTLE);
                13: chk("last SETTLE cycle", int'(bus.state), S_SETTLE);
                14: begin
                        chk("enter INIT", int'(bus.state), S_INIT);
                        chk("tx enabled in INIT", int'(bus.tx_disable), 0);
                    end
                29: chk("last INIT cycle", int'(bus.state), S_INIT);
                30: chk("enter READY", int'(bus.state), S_READY);
                31: chk("link_ready", int'(bus.link_ready), 1);
                default: ;
            endcase
        end

        // Stuck TX_FAULT runs out the retries into FAULT_LOCK.
        hold(75, 1'b0, 1'b0, 1'b1, 1'b0);
        settle_sample();
        chk("fault_latched", int'(bus.fault_latched), 1);
        chk("state FAULT_LOCK", int'(bus.state), S_LOCK);

        // Clear the fault then release the lock.
        hold(8, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle_sample();
        chk("fault_clr -> INIT", int'(bus.state), S_INIT);
        chk("fault_clr tx_disable", int'(bus.tx_disable), 0);

        // Reach FAULT_RST again, then pull the module.
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            settle_sample();
            if (bus.state == 3'(S_FRST)) hit = 1'b1;
        end
        chk("reached FAULT_RST within budget", int'(hit), 1);
        hold(8, 1'b1, 1'b0, 1'b1, 1'b0);
        settle_sample();
        chk("removal -> ABSENT", int'(bus.state), S_ABSENT);
        chk("removal tx_disable", int'(bus.tx_disable), 1);

        // Short presence glitches must not register.
        hold(10, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            hold(3, 1'b0, 1'b0, 1'b0, 1'b0);
            hold(4, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        settle_sample();
        chk("glitch present", int'(bus.sfp_present), 0);
        chk("glitch state", int'(bus.state), S_ABSENT);

        // Reinsert with a stuck fault: full retry budget again after removal.
        hold(100, 1'b0, 1'b0, 1'b1, 1'b0);
        settle_sample();
        chk("relock after reinsertion", int'(bus.fault_latched), 1);
        hold(10, 1'b1, 1'b1, 1'b0, 1'b0);

        // Repeated insertions saturate the insertion counter.
        for (int i = 0; i < 4; i++) begin
            hold(20, 1'b0, 1'b0, 1'b0, 1'b0);
            hold(10, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        settle_sample();
        chk("cnt_insert saturated", int'(bus.cnt_insert), CNT_EN ? 3 : 0);

        // Random pin activity with held runs so the debouncers sometimes pass.
        a = 1'b0; l = 1'b0; f = 1'b0; frc = 1'b0;
        ra = 0; rl = 0; rf = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ra == 0) begin a = ($urandom_range(0, 9) < 2); ra = $urandom_range(1, 30); end
            if (rl == 0) begin l = ($urandom_range(0, 9) < 3); rl = $urandom_range(1, 12); end
            if (rf == 0) begin f = ($urandom_range(0, 9) < 3); rf = $urandom_range(1, 12); end
            ra--; rl--; rf--;
            if ($urandom_range(0, 99) < 3) frc = ~frc;
            step(a, l, f, frc, ($urandom_range(0, 29) == 0));
        end

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
